// File: rtl/trigger_ctrl.sv
// Command-side trigger controller: decodes SUMP opcodes into trigger config
// strobes and sequences arm -> wait for run -> post-trigger count -> done.
module trigger_ctrl #(
   parameter int DLY_W = 16
) (
   input  logic        clk_i,
   input  logic        rst_in,
   input  logic [7:0]  opc_i,
   input  logic [31:0] data_i,
   input  logic        exec_i,
   input  logic        stb_i,
   input  logic        run_i,
   output logic [31:0] cmd_o,
   output logic        set_mask_o,
   output logic        set_val_o,
   output logic        set_cfg_o,
   output logic [1:0]  stg_o,
   output logic        arm_o,
   output logic        trg_rst_on,
   output logic        cap_en_o,
   output logic        done_o,
   output logic        id_o
);

   // state   | meaning
   // IDLE    | accepting config, delay and arm commands
   // ARMED   | trigger armed, waiting for run_i
   // CAPTURE | counting post-trigger sample strobes toward 4*(dly+1)
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

   state_t           state_q, state_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [DLY_W+1:0] cnt_q, cnt_d;
   logic [DLY_W+1:0] target;
   logic [31:0]      cmd_d;
   logic [1:0]       stg_d;
   logic             set_mask_d, set_val_d, set_cfg_d;
   logic             arm_d, id_d, trg_rst_d, done_d, cap_en_d;
   logic             is_rst, is_arm, is_id, is_dly, is_cfg, terminal;

   assign is_rst = exec_i && (opc_i == 8'h00);
   assign is_arm = exec_i && (opc_i == 8'h01);
   assign is_id  = exec_i && (opc_i == 8'h02);
   assign is_dly = exec_i && (opc_i == 8'h81);
   assign is_cfg = exec_i && (opc_i[7:4] == 4'hC) && (opc_i[1:0] != 2'b11);

   // 4*(dly+1)-1 == {dly, 2'b11}: exact at DLY_W+2 bits, never overflows
   assign target   = {dly_q, 2'b11};
   assign terminal = (state_q == CAPTURE) && stb_i && (cnt_q == target);

   always_comb begin
      state_d    = state_q;
      dly_d      = dly_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_o;
      stg_d      = stg_o;
      set_mask_d = 1'b0;
      set_val_d  = 1'b0;
      set_cfg_d  = 1'b0;
      arm_d      = 1'b0;
      id_d       = 1'b0;
      trg_rst_d  = 1'b1;
      done_d     = 1'b0;
      if (is_rst) begin
         state_d   = IDLE;
         cnt_d     = '0;
         trg_rst_d = 1'b0;
      end else if (terminal) begin
         state_d = IDLE;
         cnt_d   = '0;
         done_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_cfg) begin
                  cmd_d      = data_i;
                  stg_d      = opc_i[3:2];
                  set_mask_d = (opc_i[1:0] == 2'b00);
                  set_val_d  = (opc_i[1:0] == 2'b01);
                  set_cfg_d  = (opc_i[1:0] == 2'b10);
               end
               if (is_dly) dly_d = DLY_W'(data_i[31:16]);
               if (is_arm) begin
                  arm_d   = 1'b1;
                  state_d = ARMED;
               end
               if (is_id) id_d = 1'b1;
            end
            ARMED: begin
               if (is_id) id_d = 1'b1;
               if (run_i) begin
                  state_d = CAPTURE;
                  cnt_d   = '0;
               end
            end
            CAPTURE: begin
               if (is_id) id_d = 1'b1;
               if (stb_i) cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
      // capture stays enabled through the done cycle itself
      cap_en_d = (state_d != IDLE) || done_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         dly_q      <= '0;
         cnt_q      <= '0;
         cmd_o      <= '0;
         stg_o      <= '0;
         set_mask_o <= 1'b0;
         set_val_o  <= 1'b0;
         set_cfg_o  <= 1'b0;
         arm_o      <= 1'b0;
         id_o       <= 1'b0;
         trg_rst_on <= 1'b1;
         done_o     <= 1'b0;
         cap_en_o   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dly_q      <= dly_d;
         cnt_q      <= cnt_d;
         cmd_o      <= cmd_d;
         stg_o      <= stg_d;
         set_mask_o <= set_mask_d;
         set_val_o  <= set_val_d;
         set_cfg_o  <= set_cfg_d;
         arm_o      <= arm_d;
         id_o       <= id_d;
         trg_rst_on <= trg_rst_d;
         done_o     <= done_d;
         cap_en_o   <= cap_en_d;
      end
   end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed bench for trigger_ctrl: decode, acquisition, lockout, abort, edges.
module tb_trigger_ctrl;

   logic        clk_i;
   logic        rst_in;
   logic [7:0]  opc_i;
   logic [31:0] data_i;
   logic        exec_i, stb_i, run_i;
   logic [31:0] cmd_o;
   logic        set_mask_o, set_val_o, set_cfg_o;
   logic [1:0]  stg_o;
   logic        arm_o, trg_rst_on, cap_en_o, done_o, id_o;

   int total = 0;
   int bad   = 0;

   trigger_ctrl #(.DLY_W(16)) dut (
      .clk_i(clk_i), .rst_in(rst_in), .opc_i(opc_i), .data_i(data_i),
      .exec_i(exec_i), .stb_i(stb_i), .run_i(run_i), .cmd_o(cmd_o),
      .set_mask_o(set_mask_o), .set_val_o(set_val_o), .set_cfg_o(set_cfg_o),
      .stg_o(stg_o), .arm_o(arm_o), .trg_rst_on(trg_rst_on),
      .cap_en_o(cap_en_o), .done_o(done_o), .id_o(id_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // one-cycle exec; on return the outputs show the cycle after the command
   task automatic do_exec(input logic [7:0] opc, input logic [31:0] data);
      opc_i  = opc;
      data_i = data;
      exec_i = 1'b1;
      tick();
      exec_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         opc_i  = 8'($urandom);
         data_i = $urandom;
         exec_i = 1'($urandom);
         stb_i  = 1'($urandom);
         run_i  = 1'($urandom);
         tick();
      end
      total++;
      if ({set_mask_o, set_val_o, set_cfg_o, arm_o, id_o, done_o, cap_en_o} !== 7'b0) begin
         bad++;
         $display("FAIL reset_pulses got=%b want=0000000",
                  {set_mask_o, set_val_o, set_cfg_o, arm_o, id_o, done_o, cap_en_o});
      end
      total++;
      if (trg_rst_on !== 1'b1) begin
         bad++; $display("FAIL reset_trg_rst got=%b want=1", trg_rst_on);
      end
      total++;
      if (cmd_o !== 32'h0 || stg_o !== 2'd0) begin
         bad++; $display("FAIL reset_cmd got=%h/%0d want=0/0", cmd_o, stg_o);
      end
      rst_in = 1'b1;
      exec_i = 1'b0; stb_i = 1'b0; run_i = 1'b0; opc_i = 8'h0; data_i = 32'h0;
      tick();
   endtask

   task automatic test_config;
      do_exec(8'hC4, 32'hDEADBEEF);
      total++;
      if (set_mask_o !== 1'b1 || stg_o !== 2'd1 || cmd_o !== 32'hDEADBEEF || set_val_o || set_cfg_o) begin
         bad++; $display("FAIL cfg_mask1 got=%b/%0d/%h want=1/1/deadbeef", set_mask_o, stg_o, cmd_o);
      end
      tick();
      total++;
      if (set_mask_o !== 1'b0 || cmd_o !== 32'hDEADBEEF) begin
         bad++; $display("FAIL cfg_mask_hold got=%b/%h want=0/deadbeef", set_mask_o, cmd_o);
      end
      do_exec(8'hCE, 32'h5);
      total++;
      if (set_cfg_o !== 1'b1 || stg_o !== 2'd3 || cmd_o !== 32'h5 || set_mask_o || set_val_o) begin
         bad++; $display("FAIL cfg_cfg3 got=%b/%0d/%h want=1/3/5", set_cfg_o, stg_o, cmd_o);
      end
      do_exec(8'hC9, 32'h77);
      total++;
      if (set_val_o !== 1'b1 || stg_o !== 2'd2 || cmd_o !== 32'h77) begin
         bad++; $display("FAIL cfg_val2 got=%b/%0d/%h want=1/2/77", set_val_o, stg_o, cmd_o);
      end
      do_exec(8'hC3, 32'h1234);
      total++;
      if ({set_mask_o, set_val_o, set_cfg_o, arm_o, id_o} !== 5'b0 || cmd_o !== 32'h77 || stg_o !== 2'd2) begin
         bad++; $display("FAIL cfg_c3_ignored got=%b/%h want=00000/77",
                         {set_mask_o, set_val_o, set_cfg_o, arm_o, id_o}, cmd_o);
      end
      do_exec(8'h02, 32'h0);
      total++;
      if (id_o !== 1'b1) begin
         bad++; $display("FAIL id_idle got=%b want=1", id_o);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      opc_i = 8'hC0; data_i = 32'h1; exec_i = 1'b1;
      tick();
      total++;
      if (set_mask_o !== 1'b1 || stg_o !== 2'd0 || cmd_o !== 32'h1) begin
         bad++; $display("FAIL b2b_0 got=%b/%0d/%h want=1/0/1", set_mask_o, stg_o, cmd_o);
      end
      opc_i = 8'hC5; data_i = 32'h2;
      tick();
      total++;
      if (set_val_o !== 1'b1 || set_mask_o !== 1'b0 || stg_o !== 2'd1 || cmd_o !== 32'h2) begin
         bad++; $display("FAIL b2b_1 got=%b%b/%0d/%h want=10/1/2", set_val_o, set_mask_o, stg_o, cmd_o);
      end
      opc_i = 8'hCA; data_i = 32'h3;
      tick();
      total++;
      if (set_cfg_o !== 1'b1 || set_val_o !== 1'b0 || stg_o !== 2'd2 || cmd_o !== 32'h3) begin
         bad++; $display("FAIL b2b_2 got=%b%b/%0d/%h want=10/2/3", set_cfg_o, set_val_o, stg_o, cmd_o);
      end
      opc_i = 8'h02; data_i = 32'h0;
      tick();
      total++;
      if (id_o !== 1'b1 || set_cfg_o !== 1'b0 || cmd_o !== 32'h3) begin
         bad++; $display("FAIL b2b_id got=%b%b/%h want=10/3", id_o, set_cfg_o, cmd_o);
      end
      exec_i = 1'b0;
      tick();
      total++;
      if ({set_mask_o, set_val_o, set_cfg_o, id_o} !== 4'b0) begin
         bad++; $display("FAIL b2b_quiet got=%b want=0000", {set_mask_o, set_val_o, set_cfg_o, id_o});
      end
   endtask

   task automatic test_acquisition;
      do_exec(8'h81, 32'h0002_ABCD);
      tick();
      do_exec(8'h01, 32'h0);
      total++;
      if (arm_o !== 1'b1 || cap_en_o !== 1'b1) begin
         bad++; $display("FAIL acq_arm got=%b/%b want=1/1", arm_o, cap_en_o);
      end
      stb_i = 1'b1;
      tick();
      stb_i = 1'b0;
      total++;
      if (arm_o !== 1'b0 || cap_en_o !== 1'b1) begin
         bad++; $display("FAIL acq_arm_one got=%b/%b want=0/1", arm_o, cap_en_o);
      end
      run_i = 1'b1; stb_i = 1'b1;
      tick();
      run_i = 1'b0; stb_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         stb_i = 1'b1;
         tick();
         stb_i = 1'b0;
         total++;
         if (done_o !== (i == 11) || cap_en_o !== 1'b1) begin
            bad++; $display("FAIL acq_strobe%0d done=%b cap_en=%b want=%b/1", i, done_o, cap_en_o, i == 11);
         end
         tick();
         total++;
         if (done_o !== 1'b0 || cap_en_o !== (i != 11)) begin
            bad++; $display("FAIL acq_gap%0d done=%b cap_en=%b want=0/%b", i, done_o, cap_en_o, i != 11);
         end
      end
   endtask

   task automatic test_lockout;
      cmd_o_check: begin
         do_exec(8'h01, 32'h0);
         tick();
         do_exec(8'hC0, 32'hFFFF_0000);
         total++;
         if (set_mask_o !== 1'b0 || cmd_o !== 32'h3) begin
            bad++; $display("FAIL lock_cfg got=%b/%h want=0/3", set_mask_o, cmd_o);
         end
         do_exec(8'h01, 32'h0);
         total++;
         if (arm_o !== 1'b0) begin
            bad++; $display("FAIL lock_arm got=%b want=0", arm_o);
         end
         do_exec(8'h02, 32'h0);
         total++;
         if (id_o !== 1'b1 || cap_en_o !== 1'b1) begin
            bad++; $display("FAIL lock_id got=%b/%b want=1/1", id_o, cap_en_o);
         end
         do_exec(8'h00, 32'h0);
         total++;
         if (trg_rst_on !== 1'b0 || cap_en_o !== 1'b0) begin
            bad++; $display("FAIL lock_softrst got=%b/%b want=0/0", trg_rst_on, cap_en_o);
         end
         tick();
         total++;
         if (trg_rst_on !== 1'b1) begin
            bad++; $display("FAIL lock_softrst_one got=%b want=1", trg_rst_on);
         end
      end
   endtask

   task automatic test_abort;
      do_exec(8'h81, 32'h0001_0000);
      do_exec(8'h01, 32'h0);
      run_i = 1'b1; tick(); run_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         stb_i = 1'b1; tick(); stb_i = 1'b0; tick();
      end
      do_exec(8'h00, 32'h0);
      total++;
      if (trg_rst_on !== 1'b0 || done_o !== 1'b0 || cap_en_o !== 1'b0) begin
         bad++; $display("FAIL abort_rst got=%b/%b/%b want=0/0/0", trg_rst_on, done_o, cap_en_o);
      end
      do_exec(8'h01, 32'h0);
      total++;
      if (arm_o !== 1'b1 || trg_rst_on !== 1'b1) begin
         bad++; $display("FAIL abort_rearm got=%b/%b want=1/1", arm_o, trg_rst_on);
      end
      run_i = 1'b1; tick(); run_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         stb_i = 1'b1; tick(); stb_i = 1'b0;
         total++;
         if (done_o !== (i == 7)) begin
            bad++; $display("FAIL abort_recount%0d got=%b want=%b", i, done_o, i == 7);
         end
      end
      tick();
   endtask

   task automatic test_edges;
      logic early;
      do_exec(8'h81, 32'h0000_0000);
      do_exec(8'h01, 32'h0);
      run_i = 1'b1; tick(); run_i = 1'b0;
      stb_i = 1'b1; tick(); tick(); tick();
      opc_i = 8'h00; exec_i = 1'b1;
      tick();
      exec_i = 1'b0; stb_i = 1'b0;
      total++;
      if (done_o !== 1'b0 || trg_rst_on !== 1'b0 || cap_en_o !== 1'b0) begin
         bad++; $display("FAIL edge_rst_vs_done got=%b/%b/%b want=0/0/0", done_o, trg_rst_on, cap_en_o);
      end
      tick();
      total++;
      if (done_o !== 1'b0) begin
         bad++; $display("FAIL edge_rst_vs_done_late got=%b want=0", done_o);
      end
      // dly=0x4000 needs 65540 strobes, so the count must reach bit 16
      do_exec(8'h81, 32'h4000_0000);
      do_exec(8'h01, 32'h0);
      run_i = 1'b1; tick(); run_i = 1'b0;
      early = 1'b0;
      stb_i = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         tick();
         if (i < 65539 && done_o) early = 1'b1;
      end
      stb_i = 1'b0;
      total++;
      if (early !== 1'b0 || done_o !== 1'b1) begin
         bad++; $display("FAIL edge_wide_count early=%b done=%b want=0/1", early, done_o);
      end
      tick();
      total++;
      if (done_o !== 1'b0 || cap_en_o !== 1'b0) begin
         bad++; $display("FAIL edge_wide_after got=%b/%b want=0/0", done_o, cap_en_o);
      end
   endtask

   initial begin
      rst_in = 1'b0; opc_i = 8'h0; data_i = 32'h0;
      exec_i = 1'b0; stb_i = 1'b0; run_i = 1'b0;
      test_reset();
      test_config();
      test_back_to_back();
      test_acquisition();
      test_lockout();
      test_abort();
      test_edges();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
